pc_seq: RTL
===========

Name: pc_seq

Overview:
Parametrised program-counter sequencer and the successor to the single-jump PC register.
- Selects the next fetch address from five sources: sequential increment, jump/branch, call/return through a return-address stack (RAS), trap entry, and trap return.
- Holds the exception PC (EPC) and flags misaligned jump targets.
- Sits between decode/execute redirect logic and the instruction-fetch address port.

Parameters:
XLEN, 32, PC and data width in bits.
RESET_VEC, 32'h0000_0000, value loaded into pc_out on reset.
TRAP_VEC, 32'h0000_0100, trap-entry target address.
INC, 4, sequential increment in bytes.
ALIGN_BITS, 2, number of low target bits that must be zero. 2 gives 4-byte alignment.
RAS_DEPTH, 4, number of RAS entries. Must be ≥2 and a power of two.

Ports:
clk  in  1  System clock; all state updates on the rising edge.
rst  in  1  Asynchronous, active-low reset; asserted when 0.
stall  in  1  Hold the PC; blocks the sequential increment only.
pc_jmp  in  1  Redirect to pc_in.
call  in  1  Qualifies pc_jmp: push pc_out+INC onto the RAS.
ret  in  1  Return: pop the RAS and redirect.
trap  in  1  Trap entry.
mret  in  1  Trap return.
pc_in  in  XLEN  Jump target; also the fallback target for ret.
pc_out  out  XLEN  Current fetch PC (registered).
pc_seq_out  out  XLEN  pc_out+INC (combinational), for the link register.
epc_out  out  XLEN  Saved exception PC (registered).
misalign  out  1  One-cycle pulse: a misaligned jump target was rejected.
ras_empty  out  1  RAS count == 0.
ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): pc_out=RESET_VEC, epc_out=0, misalign=0, RAS count=0, RAS pointer=0, ras_empty=1, ras_full=0. Takes effect immediately, including mid-operation. First increment is on the first rising edge after rst returns to 1.
- Per-edge priority, highest first:
  1. trap: pc_out←TRAP_VEC; epc_out←pc_out. RAS unchanged.
  2. mret: pc_out←epc_out.
  3. ret: if RAS non-empty, pc_out←RAS top and pop; if empty, pc_out←pc_in with no pop.
  4. pc_jmp with aligned pc_in: pc_out←pc_in. If call=1, push pc_out+INC.
  5. pc_jmp with pc_in[ALIGN_BITS-1:0]≠0: target rejected. pc_out←TRAP_VEC; epc_out←pc_out; misalign=1 for exactly one cycle. No push.
  6. stall: pc_out holds.
  7. Otherwise: pc_out←pc_out+INC.
- Redirect vs stall: all redirects (items 1–5) override stall. stall gates the increment only.
- Arithmetic: modulo 2^XLEN. 0xFFFF_FFFC+4 wraps to 0x0000_0000; pc_seq_out wraps the same way.
- RAS: circular buffer of RAS_DEPTH entries, with a top pointer and a saturating count.
  - Push when full: overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop when empty: never decrements below 0.
- ret and call with pc_jmp in the same cycle: ret wins the target. The stack pops then pushes, so the top is replaced by pc_out+INC and count is unchanged.
- Lower-priority stack effects: call without pc_jmp has no effect. When trap or mret wins the edge, call/ret/pc_jmp cause no RAS change.
- Timing: single-cycle latency on all paths. The new pc_out is visible one edge after the request. No combinational path from inputs to pc_out or epc_out.

Test Plan:
- Reset then increment: rst=0 for 20 ns, release → pc_out 0x0, 0x4, 0x8, 0xC on successive edges. Assert rst=0 mid-run → pc_out=0x0 immediately, without waiting for an edge.
- Jump and wrap: pc_jmp=1, pc_in=0xFFFF_FFF8 for one cycle → 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x4. Same sequence with stall=1 held → jump still taken, then pc_out holds 0xFFFF_FFF8.
- Call/return:
  - At pc=0x10, call+pc_jmp to 0x200 → pc_out=0x200 and the RAS holds 0x14; increment to 0x208.
  - ret → pc_out=0x14; ras_empty=1.
  - ret with empty RAS and pc_in=0x300 → pc_out=0x300.
- RAS overflow: 5 calls with RAS_DEPTH=4, link values A..E → ras_full=1. Four rets return E, D, C, B. The fifth ret falls back to pc_in.
- Misaligned jump: at pc=0x40, pc_jmp with pc_in=0x102 → pc_out=0x100, epc_out=0x40, misalign high for exactly one cycle.
- Trap/mret priority: at pc=0x80 with trap, mret, pc_jmp and stall all asserted → pc_out=0x100, epc_out=0x80. A later mret → pc_out=0x80.

Source files
------------

// File: rtl/pc_seq.sv
// Program-counter sequencer: sequential/jump/call/return/trap/mret next-PC selection
// with a circular return-address stack, saved exception PC and misalignment flag.
module pc_seq #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h0000_0100),
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pc_jmp,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic            mret,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_seq_out,
  output logic [XLEN-1:0] epc_out,
  output logic            misalign,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);
  localparam logic [XLEN-1:0] AlignMask = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misalign_q, misalign_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            ras_we;
  logic [PtrW-1:0] ras_waddr;
  logic            do_push, do_pop, do_replace;
  logic            tgt_misaligned;

  assign pc_seq_out     = pc_q + XLEN'(INC);
  assign tgt_misaligned = |(pc_in & AlignMask);
  assign ras_empty      = (cnt_q == '0);
  assign ras_full       = (cnt_q == CntMax);

  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;

    if (trap) begin
      pc_d  = TRAP_VEC;
      epc_d = pc_q;
    end else if (mret) begin
      pc_d = epc_q;
    end else if (ret) begin
      // A call in the same cycle turns the pop+push into an in-place replace.
      if (!ras_empty) begin
        pc_d = ras_q[ptr_q];
        if (call && pc_jmp) do_replace = 1'b1;
        else                do_pop     = 1'b1;
      end else begin
        pc_d    = pc_in;
        do_push = call && pc_jmp;
      end
    end else if (pc_jmp) begin
      if (tgt_misaligned) begin
        pc_d       = TRAP_VEC;
        epc_d      = pc_q;
        misalign_d = 1'b1;
      end else begin
        pc_d    = pc_in;
        do_push = call;
      end
    end else if (!stall) begin
      pc_d = pc_seq_out;
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = ptr_q;
    if (do_push) begin
      // When full, ptr+1 is the oldest slot, so it gets overwritten.
      ptr_d     = ptr_q + PtrOne;
      ras_waddr = ptr_q + PtrOne;
      ras_we    = 1'b1;
      if (!ras_full) cnt_d = cnt_q + CntOne;
    end else if (do_pop) begin
      ptr_d = ptr_q - PtrOne;
      cnt_d = cnt_q - CntOne;
    end else if (do_replace) begin
      ras_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      misalign_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (ras_we) begin
      ras_q[ras_waddr] <= pc_seq_out;
    end
  end

  assign pc_out   = pc_q;
  assign epc_out  = epc_q;
  assign misalign = misalign_q;

endmodule
